vga_nios_pxl_in: RTL and testbench
==================================

Name: vga_nios_pxl_in

Overview:
- Avalon-MM slave input PIO: the read-side counterpart of the pixel-data output PIO.
- Samples an external WIDTH-bit status bus (e.g. VGA frame-done, vsync, button lines) into the clk domain through a synchroniser.
- Detects edges and latches them in a sticky edge-capture register.
- Raises a maskable level interrupt to the Nios.
- Register map is address-compatible with the output PIO (2-bit word address, 32-bit data).

Parameters:
- WIDTH, 4, number of input bits (1..32).
- EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any.
- SYNC_STAGES, 2, synchroniser flop depth (2..4).

Ports:
- clk  in  1  system clock; every flop is in this domain.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  32  Avalon write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  Avalon read data, combinational from address.
- irq  out  1  level interrupt, active high.

Behaviour:
- One clock domain. Reset is asynchronous and active-low; reset_n low clears all flops immediately.
- Reset values: sync chain 0, prev 0, irq_mask 0, edge_cap 0, irq 0. readdata reflects the reset state.
- Synchroniser: in_port passes through SYNC_STAGES flops to give sync_q. prev holds sync_q delayed by one clk.
- Edge detect:
  - rising = sync_q & ~prev
  - falling = ~sync_q & prev
  - any = sync_q ^ prev
  - EDGE_TYPE selects which one drives edge_det.
- Latency: an in_port change that meets setup appears in sync_q after SYNC_STAGES clks. It sets edge_cap one clk later. irq asserts in the same cycle as edge_cap, because irq is combinational from the registers.
- Register map (write = chipselect & ~write_n; read data is 0-extended to 32 bits):
  - addr 0 DATA: read returns sync_q. Writes are ignored.
  - addr 1 reserved: read returns 0. Writes are ignored.
  - addr 2 IRQ_MASK: read/write WIDTH bits, writedata[WIDTH-1:0].
  - addr 3 EDGE_CAP: read returns edge_cap. Writes clear it (see Optional Feature).
- edge_cap update each clk: edge_cap_next = (edge_cap & ~clr) | edge_det. Set wins over clear, so an edge arriving in the same cycle as a clear write stays captured.
- irq = |(edge_cap & irq_mask). It is a level output and stays high until software clears or masks the source bits.
- Reads have zero wait states and no side effects; reading EDGE_CAP does not clear it.
- Reset mid-operation: captured edges are lost. After reset release, prev and sync start at 0, so an input held high produces one rising edge SYNC_STAGES+1 clks after release. This is intended behaviour and software must tolerate it.
- Input toggling on consecutive clks: every detected edge ORs into edge_cap. There is no counting.

Optional Feature:
- Macro VGA_PXL_IN_BITCLR_EN.
- Defined: a write to addr 3 clears only the bits where writedata[i]=1 (write-1-to-clear); all other bits are preserved.
- Undefined: any write to addr 3 clears all edge_cap bits, regardless of writedata.

Decomposition:
- Package vga_nios_pio_pkg holds:
  - address constants PIO_ADDR_DATA=0, PIO_ADDR_RSVD=1, PIO_ADDR_IRQMASK=2, PIO_ADDR_EDGECAP=3;
  - EDGE_TYPE encodings EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- One sub-module, vga_nios_pxl_in_sync. It contains the SYNC_STAGES synchroniser, the prev flop and the edge select, and outputs sync_q and edge_det. The top level holds the registers, read mux and irq.

Test Plan:
- Reset release with in_port=4'hA, EDGE_TYPE=0: after SYNC_STAGES+1 clks edge_cap=4'hA and irq=0 (mask 0); a read of addr 0 returns 32'h0000000A.
- Write addr 2 = 4'h2, then pulse in_port[1] 0→1: irq rises SYNC_STAGES+1 clks after the pulse; a read of addr 3 returns 32'h2.
- With VGA_PXL_IN_BITCLR_EN, edge_cap=4'h6: write addr 3 = 4'h2 → edge_cap=4'h4. Without the macro, the same write → edge_cap=4'h0.
- Rising edge on in_port[0] detected in the same clk as a clear write to addr 3: edge_cap[0]=1 afterwards (set wins).
- EDGE_TYPE=2, toggle in_port[3] high then low, with a clear between the toggles: edge_cap[3] is set after each transition. Writes to addr 0 and addr 1 do not change any readback value.
- Assert reset_n low mid-operation with irq=1: irq and edge_cap drop to 0 within the same cycle, asynchronously, and a read of addr 2 returns 0.

Source files
------------

// File: rtl/vga_nios_pio_pkg.sv
// Shared constants for the Nios VGA PIO blocks: Avalon register map and edge-type encodings.
package vga_nios_pio_pkg;

  localparam int unsigned PIO_ADDR_W = 2;
  localparam int unsigned PIO_DATA_W = 32;

  localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/vga_nios_pxl_in_if.sv
// Avalon-MM slave bus bundle for the PIO blocks (2-bit word address, 32-bit data).
interface vga_nios_pxl_in_if;
  import vga_nios_pio_pkg::*;

  logic [PIO_ADDR_W-1:0] address;
  logic                  chipselect;
  logic                  write_n;
  logic [PIO_DATA_W-1:0] writedata;
  logic [PIO_DATA_W-1:0] readdata;

  modport master (output address, output chipselect, output write_n,
                  output writedata, input readdata);
  modport slave  (input address, input chipselect, input write_n,
                  input writedata, output readdata);
endinterface

// File: rtl/vga_nios_pxl_in_sync.sv
// Input synchroniser chain, one-clk history flop and edge detector for the input PIO.
module vga_nios_pxl_in_sync
  import vga_nios_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_in_port,
  output logic [WIDTH-1:0] o_sync_q,
  output logic [WIDTH-1:0] o_edge_det
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_prev;

  // Stage 0 samples the asynchronous pins; the last stage is the synchronised value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in_port};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync_q = r_sync[SYNC_STAGES-1];

  always_comb begin
    o_edge_det = '0;
    case (EDGE_TYPE)
      EDGE_RISE: o_edge_det = o_sync_q & ~r_prev;
      EDGE_FALL: o_edge_det = ~o_sync_q & r_prev;
      default:   o_edge_det = o_sync_q ^ r_prev;
    endcase
  end

endmodule

// File: rtl/vga_nios_pxl_in.sv
// Avalon-MM input PIO: synchronised status inputs, sticky edge capture and maskable level irq.
// Build option VGA_PXL_IN_BITCLR_EN makes EDGE_CAP writes write-1-to-clear per bit.
module vga_nios_pxl_in
  import vga_nios_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  vga_nios_pxl_in_if.slave    bus,
  input  logic [WIDTH-1:0]    in_port,
  output logic                irq
);

  logic [WIDTH-1:0] w_sync_q;
  logic [WIDTH-1:0] w_edge_det;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic             w_wr_ecap;
  logic             w_unused_wdata;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;

  vga_nios_pxl_in_sync #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_in_port  (in_port),
    .o_sync_q   (w_sync_q),
    .o_edge_det (w_edge_det)
  );

  assign w_wr           = bus.chipselect & ~bus.write_n;
  assign w_wr_ecap      = w_wr && (bus.address == PIO_ADDR_EDGECAP);
  assign w_unused_wdata = ^bus.writedata;

`ifdef VGA_PXL_IN_BITCLR_EN
  assign w_clr = w_wr_ecap ? bus.writedata[WIDTH-1:0] : '0;
`else
  assign w_clr = {WIDTH{w_wr_ecap}};
`endif

  // Newly detected edges are ORed in after the clear, so a same-cycle edge survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= '0;
      r_edge_cap <= '0;
    end else begin
      if (w_wr && (bus.address == PIO_ADDR_IRQMASK)) begin
        r_irq_mask <= bus.writedata[WIDTH-1:0];
      end
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge_det;
    end
  end

  assign irq = |(r_edge_cap & r_irq_mask);

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      PIO_ADDR_DATA:    bus.readdata = PIO_DATA_W'(w_sync_q);
      PIO_ADDR_IRQMASK: bus.readdata = PIO_DATA_W'(r_irq_mask);
      PIO_ADDR_EDGECAP: bus.readdata = PIO_DATA_W'(r_edge_cap);
      default:          bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_vga_nios_pxl_in.sv
// Directed bench for vga_nios_pxl_in: rising-edge 2-stage instance plus any-edge 3-stage instance.
module tb_vga_nios_pxl_in;
  import vga_nios_pio_pkg::*;

  localparam int unsigned LAT1 = 3;  // SYNC_STAGES(2) + 1
  localparam int unsigned LAT2 = 4;  // SYNC_STAGES(3) + 1

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  in1, in2;
  logic        irq1, irq2;
  logic [31:0] rd;
  int          checks = 0;
  int          errors = 0;

  vga_nios_pxl_in_if bus1();
  vga_nios_pxl_in_if bus2();

  vga_nios_pxl_in #(.WIDTH(4), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in1), .irq(irq1));

  vga_nios_pxl_in #(.WIDTH(4), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in2), .irq(irq2));

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.address = '0; bus1.writedata = '0;
    bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.address = '0; bus2.writedata = '0;
  endtask

  task automatic bus_wr(input bit sel, input logic [1:0] a, input logic [31:0] d);
    if (sel) begin
      bus2.chipselect = 1'b1; bus2.write_n = 1'b0; bus2.address = a; bus2.writedata = d;
    end else begin
      bus1.chipselect = 1'b1; bus1.write_n = 1'b0; bus1.address = a; bus1.writedata = d;
    end
    cyc(1);
    bus_idle();
  endtask

  task automatic bus_rd(input bit sel, input logic [1:0] a, output logic [31:0] d);
    if (sel) begin
      bus2.chipselect = 1'b1; bus2.write_n = 1'b1; bus2.address = a;
      #1 d = bus2.readdata;
    end else begin
      bus1.chipselect = 1'b1; bus1.write_n = 1'b1; bus1.address = a;
      #1 d = bus1.readdata;
    end
    bus_idle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in1 = 4'hA; in2 = 4'h0;
    bus_idle();
    #2;
    checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq1); end
    bus_rd(0, PIO_ADDR_DATA, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", rd); end
    bus_rd(0, PIO_ADDR_EDGECAP, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_ecap: got %h expected 00000000", rd); end
    cyc(2);
    reset_n = 1'b1;
    cyc(LAT1 - 1);
    bus_rd(0, PIO_ADDR_EDGECAP, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rel_ecap_early: got %h expected 00000000", rd); end
    bus_rd(0, PIO_ADDR_DATA, rd);
    checks++; if (rd !== 32'h0000000A) begin errors++; $display("FAIL rel_data: got %h expected 0000000a", rd); end
    cyc(1);
    bus_rd(0, PIO_ADDR_EDGECAP, rd);
    checks++; if (rd !== 32'h0000000A) begin errors++; $display("FAIL rel_ecap: got %h expected 0000000a", rd); end
    checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL rel_irq_masked: got %b expected 0", irq1); end
  endtask

  task automatic test_irq_mask();
    in1 = 4'h0;
    cyc(LAT1 + 1);
    bus_wr(0, PIO_ADDR_EDGECAP, 32'hF);
    bus_rd(0, PIO_ADDR_EDGECAP, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL irq_preclr: got %h expected 00000000", rd); end
    bus_wr(0, PIO_ADDR_IRQMASK, 32'h2);
    bus_rd(0, PIO_ADDR_IRQMASK, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL mask_rd: got %h expected 00000002", rd); end
    in1 = 4'h2;
    cyc(LAT1 - 1);
    checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq1); end
    cyc(1);
    checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", irq1); end
    bus_rd(0, PIO_ADDR_EDGECAP, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL irq_ecap: got %h expected 00000002", rd); end
  endtask

  task automatic test_clear_mode();
    logic [31:0] exp;
    in1 = 4'h6;
    cyc(LAT1);
    bus_rd(0, PIO_ADDR_EDGECAP, rd);
    checks++; if (rd !== 32'h6) begin errors++; $display("FAIL clr_pre: got %h expected 00000006", rd); end
    bus_wr(0, PIO_ADDR_EDGECAP, 32'h2);
`ifdef VGA_PXL_IN_BITCLR_EN
    exp = 32'h4;
`else
    exp = 32'h0;
`endif
    bus_rd(0, PIO_ADDR_EDGECAP, rd);
    checks++; if (rd !== exp) begin errors++; $display("FAIL clr_write: got %h expected %h", rd, exp); end
    checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL clr_irq: got %b expected 0", irq1); end
    bus_wr(0, PIO_ADDR_EDGECAP, 32'hF);
    bus_rd(0, PIO_ADDR_EDGECAP, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL clr_all: got %h expected 00000000", rd); end
  endtask

  task automatic test_set_wins();
    in1 = 4'h7;
    cyc(LAT1 - 1);
    bus_wr(0, PIO_ADDR_EDGECAP, 32'hF);
    bus_rd(0, PIO_ADDR_EDGECAP, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL set_wins: got %h expected 00000001", rd); end
  endtask

  task automatic test_any_edge();
    in2 = 4'h8;
    cyc(LAT2 - 1);
    bus_rd(1, PIO_ADDR_EDGECAP, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL any_rise_early: got %h expected 00000000", rd); end
    cyc(1);
    bus_rd(1, PIO_ADDR_EDGECAP, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL any_rise: got %h expected 00000008", rd); end
    checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL any_irq_masked: got %b expected 0", irq2); end
    bus_wr(1, PIO_ADDR_EDGECAP, 32'hF);
    bus_rd(1, PIO_ADDR_EDGECAP, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL any_clr: got %h expected 00000000", rd); end
    in2 = 4'h0;
    cyc(LAT2);
    bus_rd(1, PIO_ADDR_EDGECAP, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL any_fall: got %h expected 00000008", rd); end
  endtask

  task automatic test_ignored_writes();
    bus_wr(0, PIO_ADDR_DATA, 32'hFFFF_FFFF);
    bus_wr(0, PIO_ADDR_RSVD, 32'hFFFF_FFFF);
    bus_rd(0, PIO_ADDR_DATA, rd);
    checks++; if (rd !== 32'h7) begin errors++; $display("FAIL ign_data: got %h expected 00000007", rd); end
    bus_rd(0, PIO_ADDR_RSVD, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ign_rsvd: got %h expected 00000000", rd); end
    bus_rd(0, PIO_ADDR_IRQMASK, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL ign_mask: got %h expected 00000002", rd); end
    bus_rd(0, PIO_ADDR_EDGECAP, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ign_ecap: got %h expected 00000001", rd); end
  endtask

  task automatic test_async_reset();
    in1 = 4'h5;
    cyc(LAT1);
    in1 = 4'h7;
    cyc(LAT1);
    checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL ar_irq_pre: got %b expected 1", irq1); end
    bus_rd(0, PIO_ADDR_EDGECAP, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL ar_ecap_pre: got %h expected 00000003", rd); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL ar_irq: got %b expected 0", irq1); end
    bus_rd(0, PIO_ADDR_EDGECAP, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ar_ecap: got %h expected 00000000", rd); end
    bus_rd(0, PIO_ADDR_IRQMASK, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ar_mask: got %h expected 00000000", rd); end
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    test_reset();
    test_irq_mask();
    test_clear_mode();
    test_set_wins();
    test_any_edge();
    test_ignored_writes();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
